// File: rtl/alu_op_issuer.sv
// -----------------------------------------------------------------------------
// alu_op_issuer
//
// Command-side driver for an operand-isolated 4-op ALU (mul/add/div/sub with
// one-hot selects sel1..sel4). It accepts one {op, a, b} command at a time on a
// valid/ready port. It then drives the ALU operands and the matching select
// for ALU_LAT cycles, captures the ALU's registered result and returns it on a
// valid/ready response port. The operands are zero and every select is low
// whenever no op is being issued, so the ALU never sees toggling inputs while
// idle.
//
// A divide by zero is never issued. The issuer answers it directly with
// rsp_err=1 and rsp_data all ones.
//
// Ports
//   clk, rst                 single clock; synchronous active-high reset
//   cmd_valid/cmd_ready      command handshake (ready only in IDLE)
//   cmd_op, cmd_a, cmd_b     00 mul, 01 add, 10 div, 11 sub; operands
//   alu_a, alu_b             ALU operands, zero when not issuing
//   alu_sel1..alu_sel4       mul/add/div/sub selects, one-hot while issuing
//   alu_out                  ALU registered result, sampled in CAPTURE
//   rsp_valid/rsp_ready      response handshake
//   rsp_data, rsp_err        captured result; divide-by-zero flag
//   busy                     high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module alu_op_issuer #(
  parameter int DW      = 4,
  parameter int RW      = 8,
  parameter int ALU_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [DW-1:0] cmd_a,
  input  logic [DW-1:0] cmd_b,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic          alu_sel1,
  output logic          alu_sel2,
  output logic          alu_sel3,
  output logic          alu_sel4,
  input  logic [RW-1:0] alu_out,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [RW-1:0] rsp_data,
  output logic          rsp_err,
  output logic          busy
);

  typedef enum logic [1:0] {
    OP_MUL = 2'b00,
    OP_ADD = 2'b01,
    OP_DIV = 2'b10,
    OP_SUB = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPTURE,
    S_RESP
  } state_e;

  // Keep the counter at least one bit wide so that ALU_LAT=1 still elaborates.
  localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(ALU_LAT - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  op_e           op_q, op_d;
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  logic [RW-1:0] rsp_data_q, rsp_data_d;
  logic          rsp_err_q, rsp_err_d;

  // NOTE: every signal driven here gets a default first. Then no path through
  // the case statement can leave one unassigned, and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;

    cmd_ready  = 1'b0;
    rsp_valid  = 1'b0;
    busy       = (state_q != S_IDLE);
    alu_a      = '0;
    alu_b      = '0;
    alu_sel1   = 1'b0;
    alu_sel2   = 1'b0;
    alu_sel3   = 1'b0;
    alu_sel4   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          op_d  = op_e'(cmd_op);
          a_d   = cmd_a;
          b_d   = cmd_b;
          cnt_d = '0;
          if (op_e'(cmd_op) == OP_DIV && cmd_b == '0) begin
            // Answer locally; the ALU never sees this command.
            rsp_data_d = '1;
            rsp_err_d  = 1'b1;
            state_d    = S_RESP;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end

      S_ISSUE: begin
        alu_a = a_q;
        alu_b = b_q;
        unique case (op_q)
          OP_MUL: alu_sel1 = 1'b1;
          OP_ADD: alu_sel2 = 1'b1;
          OP_DIV: alu_sel3 = 1'b1;
          OP_SUB: alu_sel4 = 1'b1;
        endcase
        if (cnt_q == CNT_LAST) begin
          state_d = S_CAPTURE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_CAPTURE: begin
        // The operands are already isolated. The result of the first issue
        // cycle appears at alu_out now.
        rsp_data_d = alu_out;
        rsp_err_d  = 1'b0;
        state_d    = S_RESP;
      end

      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. Then every
  // register samples the values from before the edge, whatever order the
  // statements appear in.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      op_q       <= OP_MUL;
      a_q        <= '0;
      b_q        <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign rsp_data = rsp_data_q;
  assign rsp_err  = rsp_err_q;

endmodule

// File: tb/tb_alu_op_issuer.sv
// -----------------------------------------------------------------------------
// tb_alu_op_issuer
//
// Directed bench for alu_op_issuer. A small behavioural model of the
// two-stage, operand-isolated ALU feeds alu_out. Expected responses are
// hand-computed constants. Outputs are sampled on the falling edge and inputs
// are driven right after sampling.
// -----------------------------------------------------------------------------
module tb_alu_op_issuer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [3:0] cmd_a = '0;
  logic [3:0] cmd_b = '0;
  logic [3:0] alu_a, alu_b;
  logic       alu_sel1, alu_sel2, alu_sel3, alu_sel4;
  logic [7:0] alu_out;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic       busy;

  int checks = 0;
  int errors = 0;

  wire [3:0] sels = {alu_sel4, alu_sel3, alu_sel2, alu_sel1};

  always #5 clk = ~clk;

  alu_op_issuer #(.DW(4), .RW(8), .ALU_LAT(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel1  (alu_sel1),
    .alu_sel2  (alu_sel2),
    .alu_sel3  (alu_sel3),
    .alu_sel4  (alu_sel4),
    .alu_out   (alu_out),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  // Two-stage ALU model. It outputs zero when no select is high.
  logic [7:0] alu_comb;
  logic [7:0] alu_stage1 = '0;
  logic [7:0] alu_stage2 = '0;

  always_comb begin
    alu_comb = 8'h00;
    if (alu_sel1)      alu_comb = {4'h0, alu_a} * {4'h0, alu_b};
    else if (alu_sel2) alu_comb = {4'h0, alu_a} + {4'h0, alu_b};
    else if (alu_sel3) alu_comb = (alu_b != 0) ? {4'h0, alu_a} / {4'h0, alu_b} : 8'h00;
    else if (alu_sel4) alu_comb = {4'h0, alu_a} - {4'h0, alu_b};
  end

  always_ff @(posedge clk) begin
    alu_stage1 <= alu_comb;
    alu_stage2 <= alu_stage1;
  end
  assign alu_out = alu_stage2;

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({cmd_ready, rsp_valid, rsp_err, busy} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_flags got rdy/val/err/busy=%b want 1000",
               {cmd_ready, rsp_valid, rsp_err, busy});
    end
    checks++;
    if ({sels, alu_a, alu_b, rsp_data} !== 20'h0) begin
      errors++;
      $display("FAIL reset_outputs got sels=%b a=%h b=%h data=%h want all 0",
               sels, alu_a, alu_b, rsp_data);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  // T1: mul 3*5. sel1 is high for exactly two cycles, and the response comes
  // four cycles after the accept.
  task automatic test_mul();
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_a = 4'd3; cmd_b = 4'd5;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL mul_ready got %b want 1", cmd_ready);
    end
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      checks++;
      if ({sels, alu_a, alu_b, rsp_valid, cmd_ready} !== {4'b0001, 4'd3, 4'd5, 2'b00}) begin
        errors++;
        $display("FAIL mul_issue_c%0d got sels=%b a=%h b=%h val=%b rdy=%b want 0001 3 5 0 0",
                 c, sels, alu_a, alu_b, rsp_valid, cmd_ready);
      end
    end
    @(negedge clk);
    checks++;
    if ({sels, alu_a, alu_b, rsp_valid, busy} !== {12'h000, 2'b01}) begin
      errors++;
      $display("FAIL mul_capture got sels=%b a=%h b=%h val=%b busy=%b want 0 0 0 0 1",
               sels, alu_a, alu_b, rsp_valid, busy);
    end
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_err, rsp_data} !== {2'b10, 8'h0F}) begin
      errors++;
      $display("FAIL mul_resp got val=%b err=%b data=%h want 1 0 0f", rsp_valid, rsp_err, rsp_data);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if ({rsp_valid, cmd_ready, busy} !== 3'b010) begin
      errors++;
      $display("FAIL mul_done got val=%b rdy=%b busy=%b want 0 1 0", rsp_valid, cmd_ready, busy);
    end
  endtask

  // T2: add, div and sub. Only the matching select may ever be high.
  task automatic test_ops();
    logic [1:0] ops [3]  = '{2'b01, 2'b10, 2'b11};
    logic [3:0] as  [3]  = '{4'd9, 4'd13, 4'd2};
    logic [3:0] bs  [3]  = '{4'd7, 4'd4, 4'd9};
    logic [3:0] hot [3]  = '{4'b0010, 4'b0100, 4'b1000};
    logic [7:0] exp [3]  = '{8'h10, 8'h03, 8'hF9};
    for (int i = 0; i < 3; i++) begin
      cmd_valid = 1'b1; cmd_op = ops[i]; cmd_a = as[i]; cmd_b = bs[i];
      for (int c = 1; c <= 3; c++) begin
        @(negedge clk);
        cmd_valid = 1'b0;
        checks++;
        if (sels !== ((c <= 2) ? hot[i] : 4'b0000)) begin
          errors++;
          $display("FAIL op%0d_sel_c%0d got %b want %b", i, c, sels,
                   (c <= 2) ? hot[i] : 4'b0000);
        end
      end
      @(negedge clk);
      checks++;
      if ({rsp_valid, rsp_err, rsp_data} !== {2'b10, exp[i]}) begin
        errors++;
        $display("FAIL op%0d_resp got val=%b err=%b data=%h want 1 0 %h",
                 i, rsp_valid, rsp_err, rsp_data, exp[i]);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
    end
  endtask

  // T3: a divide by zero answers in the cycle after the accept and never
  // touches the ALU.
  task automatic test_div0();
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_a = 4'd7; cmd_b = 4'd0;
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if ({rsp_valid, rsp_err, rsp_data} !== {2'b11, 8'hFF}) begin
      errors++;
      $display("FAIL div0_resp got val=%b err=%b data=%h want 1 1 ff", rsp_valid, rsp_err, rsp_data);
    end
    checks++;
    if ({sels, alu_a, alu_b} !== 12'h000) begin
      errors++;
      $display("FAIL div0_isolation got sels=%b a=%h b=%h want 0", sels, alu_a, alu_b);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if ({rsp_valid, cmd_ready, sels} !== {2'b01, 4'b0000}) begin
      errors++;
      $display("FAIL div0_done got val=%b rdy=%b sels=%b want 0 1 0000", rsp_valid, cmd_ready, sels);
    end
  endtask

  // T4: backpressure. The response holds steady, and a waiting command is
  // taken only after the handshake.
  task automatic test_backpressure();
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_a = 4'd1; cmd_b = 4'd2;
    @(negedge clk);
    cmd_op = 2'b11; cmd_a = 4'd5; cmd_b = 4'd3;
    @(negedge clk);
    @(negedge clk);
    for (int c = 4; c <= 8; c++) begin
      @(negedge clk);
      checks++;
      if ({rsp_valid, rsp_err, rsp_data, cmd_ready} !== {2'b10, 8'h03, 1'b0}) begin
        errors++;
        $display("FAIL bp_hold_c%0d got val=%b err=%b data=%h rdy=%b want 1 0 03 0",
                 c, rsp_valid, rsp_err, rsp_data, cmd_ready);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      errors++;
      $display("FAIL bp_release got val=%b rdy=%b want 0 1", rsp_valid, cmd_ready);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if ({sels, alu_a, alu_b, cmd_ready} !== {4'b1000, 4'd5, 4'd3, 1'b0}) begin
      errors++;
      $display("FAIL bp_second_issue got sels=%b a=%h b=%h rdy=%b want 1000 5 3 0",
               sels, alu_a, alu_b, cmd_ready);
    end
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_data} !== {1'b1, 8'h02}) begin
      errors++;
      $display("FAIL bp_second_resp got val=%b data=%h want 1 02", rsp_valid, rsp_data);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  // T5: a reset during ISSUE drops the op, and no response ever follows.
  task automatic test_reset_mid();
    int seen = 0;
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_a = 4'd6; cmd_b = 4'd2;
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if (sels !== 4'b0001) begin
      errors++; $display("FAIL rstmid_issue got sels=%b want 0001", sels);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({sels, alu_a, alu_b, cmd_ready, busy, rsp_valid} !== {12'h000, 3'b100}) begin
      errors++;
      $display("FAIL rstmid_after got sels=%b a=%h b=%h rdy=%b busy=%b val=%b want 0 0 0 1 0 0",
               sels, alu_a, alu_b, cmd_ready, busy, rsp_valid);
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL rstmid_no_resp got %0d valid cycles want 0", seen);
    end
  endtask

  // T6: two commands back to back, with rsp_ready held high.
  task automatic test_back_to_back();
    int nacc = 0, nrsp = 0;
    int acc0 = -100, acc1 = -100, r0 = -100, r1 = -100;
    logic [7:0] d0 = 8'h00, d1 = 8'h00;
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_a = 4'd15; cmd_b = 4'd15;
    rsp_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (nacc == 1 && k > acc0) begin
        cmd_op = 2'b01;
      end
      if (nacc == 2 && k > acc1) begin
        cmd_valid = 1'b0;
      end
      if (rsp_valid === 1'b1) begin
        if (nrsp == 0) begin r0 = k; d0 = rsp_data; end
        else if (nrsp == 1) begin r1 = k; d1 = rsp_data; end
        nrsp++;
      end
      if (cmd_valid && cmd_ready === 1'b1) begin
        if (nacc == 0) acc0 = k;
        else if (nacc == 1) acc1 = k;
        nacc++;
      end
      @(negedge clk);
    end
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    checks++;
    if (nacc !== 2 || nrsp !== 2) begin
      errors++;
      $display("FAIL b2b_counts got accepts=%0d responses=%0d want 2 2", nacc, nrsp);
    end
    checks++;
    if (acc1 - acc0 !== 5) begin
      errors++; $display("FAIL b2b_spacing got %0d want 5", acc1 - acc0);
    end
    checks++;
    if (d0 !== 8'hE1 || r0 - acc0 !== 4) begin
      errors++; $display("FAIL b2b_first got data=%h lat=%0d want e1 4", d0, r0 - acc0);
    end
    checks++;
    if (d1 !== 8'h1E || r1 - acc1 !== 4) begin
      errors++; $display("FAIL b2b_second got data=%h lat=%0d want 1e 4", d1, r1 - acc1);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_ops();
    test_div0();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
